shifter_seq: RTL

Parametrised multi-cycle shifter for the stack processor datapath. It generalises the fixed-amount, fixed-direction shift helpers into one block. The block takes a WIDTH-bit operand, a run-time shift amount and a mode, then shifts one bit position per clock. It returns the result with a start/busy/done handshake, so the control unit can issue shift instructions without a wide combinational barrel shifter.

---
 rtl/shifter_seq_if.sv | 23 ++
 rtl/shifter_seq.sv | 83 ++++++++
 2 files changed

// File: rtl/shifter_seq_if.sv
// Request/response bundle for the sequential shifter.
interface shifter_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, mode, amount, din,
        input  busy, done, dout
    );

    modport slave (
        input  start, mode, amount, din,
        output busy, done, dout
    );
endinterface

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL. All outputs are registered.
module shifter_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input logic         clk,
    input logic         rst_n,
    shifter_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dout_q;

    // Single-position shift of the accumulator for the given mode.
    function automatic logic [WIDTH-1:0] step(input logic [1:0] m, input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] r;
        case (m)
            2'b00:   r = {a[WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, a[WIDTH-1:1]};
            2'b10:   r = {a[WIDTH-1], a[WIDTH-1:1]};
            default: r = {a[WIDTH-2:0], a[WIDTH-1]};
        endcase
        return r;
    endfunction

    // Control FSM with registered busy/done/dout; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                StShift: begin
                    acc_q <= step(mode_q, acc_q);
                    cnt_q <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dout_q  <= step(mode_q, acc_q);
                    end
                end
                default: begin
                    // Idle and Done both accept a new request; Done allows back-to-back.
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    if (bus.start) begin
                        acc_q  <= bus.din;
                        cnt_q  <= bus.amount;
                        mode_q <= bus.mode;
                        if (bus.amount == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            dout_q  <= bus.din;
                        end else begin
                            state_q <= StShift;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule
